// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble/flush sequencing for load-use, ID redirects and data-memory waits.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           rs_ID,
  input  logic [4:0]           rt_ID,
  input  logic                 use_rs_ID,
  input  logic                 use_rt_ID,
  input  logic                 load_EXE,
  input  logic [4:0]           num_write_EXE,
  input  logic                 redirect_ID,
  input  logic                 dm_busy,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_exe_en,
  output logic                 id_exe_bubble,
  output logic                 exe_mem_en,
  output logic                 mem_wb_bubble,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
  state_t state;
  logic [3:0] ls_cnt;
  logic [15:0] wait_cnt;
  logic lu, eff_ls, live, stall, run;
  assign lu = load_EXE && num_write_EXE != 5'd0 &&
              ((use_rs_ID && rs_ID == num_write_EXE) || (use_rt_ID && rt_ID == num_write_EXE));
  // leaving MEM_WAIT resumes an interrupted load stall if one was pending
  assign eff_ls = state == LOAD_STALL || (state == MEM_WAIT && ls_cnt != 4'd0);
  always_comb begin
    live = !reset && !dm_busy;
    stall = live && (eff_ls || lu);
    run = live && !stall;
    pc_en = run;
    if_id_en = run;
    if_id_flush = run && redirect_ID;
    id_exe_en = live;
    id_exe_bubble = stall;
    exe_mem_en = live;
    mem_wb_bubble = !reset && dm_busy;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      ls_cnt <= 4'd0;
      wait_cnt <= 16'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (dm_busy) begin
        state <= MEM_WAIT;
        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
        if (int'({16'd0, wait_cnt}) >= MEM_TIMEOUT - 1) timeout_err <= 1'b1;
      end else begin
        wait_cnt <= 16'd0;
        if (eff_ls) begin
          ls_cnt <= ls_cnt - 4'd1;
          state <= ls_cnt == 4'd1 ? RUN : LOAD_STALL;
        end else if (lu && LOAD_STALL_CYCLES > 1) begin
          ls_cnt <= 4'(LOAD_STALL_CYCLES - 1);
          state <= LOAD_STALL;
        end else begin
          state <= RUN;
        end
      end
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed checks of hazard_ctrl with LOAD_STALL_CYCLES=1 and =3.
module tb_hazard_ctrl;
  logic clock = 1'b0;
  logic reset, use_rs_ID, use_rt_ID, load_EXE, redirect_ID, dm_busy;
  logic [4:0] rs_ID, rt_ID, num_write_EXE;
  logic a_pc, a_ifen, a_fl, a_ieen, a_bub, a_emen, a_mwb, a_to;
  logic b_pc, b_ifen, b_fl, b_ieen, b_bub, b_emen, b_mwb, b_to;
  logic [15:0] a_sc, a_fc;
  logic [3:0] b_sc, b_fc;
  int total = 0, passed = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_WIDTH(16)) dut1 (
    .clock(clock), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
    .use_rt_ID(use_rt_ID), .load_EXE(load_EXE), .num_write_EXE(num_write_EXE),
    .redirect_ID(redirect_ID), .dm_busy(dm_busy), .pc_en(a_pc), .if_id_en(a_ifen),
    .if_id_flush(a_fl), .id_exe_en(a_ieen), .id_exe_bubble(a_bub), .exe_mem_en(a_emen),
    .mem_wb_bubble(a_mwb), .stall_cnt(a_sc), .flush_cnt(a_fc), .timeout_err(a_to));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut3 (
    .clock(clock), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
    .use_rt_ID(use_rt_ID), .load_EXE(load_EXE), .num_write_EXE(num_write_EXE),
    .redirect_ID(redirect_ID), .dm_busy(dm_busy), .pc_en(b_pc), .if_id_en(b_ifen),
    .if_id_flush(b_fl), .id_exe_en(b_ieen), .id_exe_bubble(b_bub), .exe_mem_en(b_emen),
    .mem_wb_bubble(b_mwb), .stall_cnt(b_sc), .flush_cnt(b_fc), .timeout_err(b_to));

  typedef struct {
    logic rst;
    logic [4:0] rs, rt;
    logic urs, urt, load;
    logic [4:0] nw;
    logic redir, busy;
    logic [6:0] ctl;
    int sc, fc;
    logic to;
  } vec_t;

  // ctl = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en, mem_wb_bubble}
  localparam logic [6:0] Z = 7'b0000000, N = 7'b1101010, S = 7'b0001110,
                         R = 7'b1111010, F = 7'b0000001;

  vec_t t1[$], t3[$];

  function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic load, logic [4:0] nw, logic redir, logic busy,
                              logic [6:0] ctl, int sc, int fc, logic to);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.load = load; v.nw = nw;
    v.redir = redir; v.busy = busy; v.ctl = ctl; v.sc = sc; v.fc = fc; v.to = to;
    return v;
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
  endtask

  task automatic run(vec_t v, bit d3, string tag, int idx);
    logic [6:0] ctl;
    @(posedge clock);
    #1;
    reset = v.rst; rs_ID = v.rs; rt_ID = v.rt; use_rs_ID = v.urs; use_rt_ID = v.urt;
    load_EXE = v.load; num_write_EXE = v.nw; redirect_ID = v.redir; dm_busy = v.busy;
    @(negedge clock);
    ctl = d3 ? {b_pc, b_ifen, b_fl, b_ieen, b_bub, b_emen, b_mwb}
             : {a_pc, a_ifen, a_fl, a_ieen, a_bub, a_emen, a_mwb};
    chk({tag, "_ctl"}, idx, int'(ctl), int'(v.ctl));
    chk({tag, "_stall_cnt"}, idx, d3 ? int'(b_sc) : int'(a_sc), v.sc);
    chk({tag, "_flush_cnt"}, idx, d3 ? int'(b_fc) : int'(a_fc), v.fc);
    chk({tag, "_timeout"}, idx, int'(d3 ? b_to : a_to), int'(v.to));
  endtask

  initial begin
    reset = 1'b1; rs_ID = '0; rt_ID = '0; use_rs_ID = 0; use_rt_ID = 0;
    load_EXE = 0; num_write_EXE = '0; redirect_ID = 0; dm_busy = 0;
    //                rst rs rt urs urt ld nw rd bsy ctl sc fc to
    t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0, 0));
    t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0));
    t1.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 0, S, 0, 0, 0));
    t1.push_back(mk(0, 8, 0, 1, 0, 0, 8, 0, 0, N, 1, 0, 0));
    t1.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, N, 1, 0, 0));
    t1.push_back(mk(0, 3, 9, 1, 0, 1, 9, 0, 0, N, 1, 0, 0));
    t1.push_back(mk(0, 3, 9, 1, 1, 1, 9, 0, 0, S, 1, 0, 0));
    t1.push_back(mk(0, 3, 9, 1, 1, 1, 9, 1, 0, S, 2, 0, 0));
    t1.push_back(mk(0, 3, 9, 1, 1, 0, 9, 1, 0, R, 3, 0, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 3, 1, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, F, 3, 1, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 4, 1, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 5, 1, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 6, 1, 0));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 7, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 8, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, R, 9, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 9, 2, 1));
    t1.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 1, F, 9, 2, 1));
    t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, Z, 10, 2, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0));

    t3.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0, 0));
    t3.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 0, S, 0, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 1, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, 2, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, S, 3, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, S, 4, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 5, 0, 0));
    t3.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 0, S, 5, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, S, 6, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, S, 7, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, R, 8, 0, 0));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 8, 1, 0));
    for (int i = 0; i < 10; i++)
      t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, F, (8 + i > 15) ? 15 : 8 + i, 1, i >= 4));
    t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 15, 1, 1));

    foreach (t1[i]) run(t1[i], 1'b0, "l1", i);
    foreach (t3[i]) run(t3[i], 1'b1, "l3", i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF/ID/EXE/MEM/WB).
- Generates the stage-register enables, bubble and flush controls from three sources:
  - load-use hazards between ID and EXE;
  - taken-redirects resolved in ID;
  - a multi-cycle data-memory wait.
- Sits beside the forwarding logic, which still covers all ALU-to-ALU hazards.
- Keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

Parameters:
- LOAD_STALL_CYCLES, 1, ID/IF freeze cycles per detected load-use hazard; legal range 1..15.
- MEM_TIMEOUT, 255, consecutive dm_busy cycles after which timeout_err sets; legal range 1..65535.
- CNT_WIDTH, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_ID  in  5  rs field of the instruction in ID.
- rt_ID  in  5  rt field of the instruction in ID.
- use_rs_ID  in  1  ID instruction reads rs.
- use_rt_ID  in  1  ID instruction reads rt.
- load_EXE  in  1  EXE instruction is a load (data_write select = DM).
- num_write_EXE  in  5  destination register of the EXE instruction.
- redirect_ID  in  1  ID resolved a taken branch/jump this cycle.
- dm_busy  in  1  data memory has not completed the MEM-stage access.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF-ID register load enable.
- if_id_flush  out  1  IF-ID loads NOP.
- id_exe_en  out  1  ID-EXE register load enable.
- id_exe_bubble  out  1  ID-EXE loads all-zero control (NOP).
- exe_mem_en  out  1  EXE-MEM register load enable.
- mem_wb_bubble  out  1  MEM-WB loads reg_write=0.
- stall_cnt  out  CNT_WIDTH  cycles with pc_en=0, saturating.
- flush_cnt  out  CNT_WIDTH  cycles with if_id_flush=1, saturating.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- State machine states: RUN, LOAD_STALL, MEM_WAIT. Internal registers:
  - ls_cnt, 4 bits: remaining load stalls.
  - wait_cnt, 16 bits: consecutive busy cycles.
- Control outputs are combinational from the state and inputs. Counters and timeout_err are registered.
- While reset is high:
  - Outputs: all enables 0; all bubble/flush outputs 0; stall_cnt=0; flush_cnt=0; timeout_err=0.
  - Registers: state=RUN, ls_cnt=0, wait_cnt=0.
  - Reset is honoured mid-stall or mid-wait with no residual effect.
- Load-use condition (lu):
  - load_EXE && num_write_EXE!=0 && ((use_rs_ID && rs_ID==num_write_EXE) || (use_rt_ID && rt_ID==num_write_EXE)).
  - r0 never hazards.
- Priority in every state: dm_busy > load stall > redirect.
- Memory freeze (dm_busy=1, any state):
  - pc_en=0, if_id_en=0, id_exe_en=0, exe_mem_en=0, mem_wb_bubble=1.
  - id_exe_bubble=0 and if_id_flush=0; redirect is ignored and must be re-presented.
  - Next state is MEM_WAIT; ls_cnt is held.
- RUN, dm_busy=0, lu=1:
  - pc_en=0, if_id_en=0, id_exe_en=1, id_exe_bubble=1, exe_mem_en=1; redirect is suppressed this cycle.
  - If LOAD_STALL_CYCLES>1: ls_cnt<=LOAD_STALL_CYCLES-1 and next state is LOAD_STALL. Otherwise stay in RUN.
- RUN, dm_busy=0, lu=0, redirect_ID=1:
  - All enables 1; if_id_flush=1, which overrides if_id_en data.
- RUN, otherwise: all enables 1, no bubble, no flush.
- LOAD_STALL, dm_busy=0:
  - Same outputs as the lu cycle.
  - ls_cnt decrements; go to RUN when ls_cnt==1 at the clock edge.
  - lu is not re-evaluated in this state.
- MEM_WAIT:
  - Freeze outputs while dm_busy=1; wait_cnt increments, saturating.
  - When dm_busy falls: wait_cnt<=0. Next state is LOAD_STALL if ls_cnt!=0, else RUN.
  - The exit cycle is evaluated with RUN/LOAD_STALL rules.
- timeout_err:
  - Sets when wait_cnt reaches MEM_TIMEOUT while dm_busy=1.
  - Cleared only by reset.
- Counters:
  - stall_cnt increments each cycle with pc_en=0; flush_cnt increments each cycle with if_id_flush=1.
  - Both hold at 2^CNT_WIDTH-1.
- Simultaneous lu and redirect: the stall wins. The redirect must still be asserted once ID is released, which occurs naturally because the instruction remains in ID.

Test Plan:
- Load-use: lw $8 in EXE with use_rs_ID=1, rs_ID=8, LOAD_STALL_CYCLES=1 -> one cycle with pc_en=0 and id_exe_bubble=1, then all enables 1; stall_cnt=1.
- r0 and no-use: num_write_EXE=0 with rs_ID=0, and separately use_rt_ID=0 with rt matching -> no stall; pc_en stays 1.
- Multi-cycle load stall: LOAD_STALL_CYCLES=3 -> exactly 3 stall cycles; dm_busy pulsed 2 cycles mid-stall -> 5 total cycles with pc_en=0, state returns to LOAD_STALL, stall_cnt=5.
- Redirect vs stall: lu and redirect_ID together -> cycle 1 stall with no flush; cycle 2 (lu clear, redirect held) if_id_flush=1; flush_cnt=1.
- Memory wait and timeout: MEM_TIMEOUT=4, dm_busy held 6 cycles -> exe_mem_en=0 and mem_wb_bubble=1 for 6 cycles; timeout_err rises after the 4th busy cycle and stays 1 after dm_busy drops.
- Reset mid-MEM_WAIT: reset=1 for 1 cycle -> next cycle state RUN, counters 0, timeout_err 0; with dm_busy=0, all enables 1.
